// File: rtl/mc51_ext_mem_resp_pkg.sv
// Shared types and defaults for the MC51 external memory responder.
// State encodings, access-type codes and the default wait count.
package mc51_ext_mem_resp_pkg;

  localparam int DEF_WAIT_CYC = 63;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    ACC_FETCH,
    ACC_READ,
    ACC_WRITE
  } acc_t;

  // Fetch wins over read, read wins over write.
  function automatic acc_t acc_sel(
    input logic psen_n,
    input logic rd_n
  );
    if (!psen_n)    return ACC_FETCH;
    else if (!rd_n) return ACC_READ;
    else            return ACC_WRITE;
  endfunction

endpackage

// File: rtl/mc51_ext_mem_resp_sp_ram.sv
// Synchronous byte RAM, one write port and one read port.
// A same-address write and read return the newly written data.
module mc51_sp_ram #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (re)
      rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/mc51_ext_mem_resp.sv
// MC51 external code/XRAM responder with programmable wait states.
// Define MC51_MEM_ERR_EN to add the mem_err out-of-range flag.
module mc51_ext_mem_resp
  import mc51_ext_mem_resp_pkg::*;
#(
  parameter int CODE_AW  = 12,
  parameter int XRAM_AW  = 10,
  parameter int WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic [15:0]        mem_addr,
  input  logic               mem_psen_n,
  input  logic               mem_rd_n,
  input  logic               mem_we_n,
  input  logic [7:0]         mem_wdata,
  output logic [7:0]         mem_rdata,
  output logic               mem_data_rdy,
`ifdef MC51_MEM_ERR_EN
  output logic               mem_err,
`endif
  input  logic               prog_we,
  input  logic [CODE_AW-1:0] prog_addr,
  input  logic [7:0]         prog_wdata
);

  state_t      state;
  state_t      nxt;
  logic [7:0]  cnt;
  logic [15:0] cap_addr;
  logic [7:0]  cap_wdata;
  acc_t        cap_acc;
  logic [7:0]  rdata_q;
  logic [7:0]  code_q;
  logic [7:0]  xram_q;
  logic [7:0]  resp_data;
  logic        start;
  logic        fire;
  logic        cap_oor;
  logic        is_rd;

  assign start = (state == ST_IDLE) &&
                 !(mem_psen_n && mem_rd_n && mem_we_n);
  // Array access happens on the edge that enters RESP.
  assign fire  = (state == ST_WAIT) && (cnt == 8'd0) && !sys_rst;
  assign is_rd = (cap_acc != ACC_WRITE);

`ifdef MC51_MEM_ERR_EN
  assign cap_oor = (cap_acc == ACC_FETCH) ?
                   ((cap_addr >> CODE_AW) != 16'd0) :
                   ((cap_addr >> XRAM_AW) != 16'd0);
  assign mem_err = (state == ST_RESP) && cap_oor;
`else
  logic unused_hi;
  assign cap_oor   = 1'b0;
  assign unused_hi = ^cap_addr;
`endif

  always_ff @(posedge clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt          = state;
    mem_data_rdy = 1'b1;
    unique case (state)
      ST_IDLE: if (start) nxt = ST_WAIT;
      ST_WAIT: begin
        mem_data_rdy = 1'b0;
        if (cnt == 8'd0) nxt = ST_RESP;
      end
      ST_RESP: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      cnt <= 8'd0;
    end else if (start) begin
      cnt       <= 8'(WAIT_CYC);
      cap_addr  <= mem_addr;
      cap_wdata <= mem_wdata;
      cap_acc   <= acc_sel(mem_psen_n, mem_rd_n);
    end else if (state == ST_WAIT && cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  always_comb begin
    resp_data = (cap_acc == ACC_FETCH) ? code_q : xram_q;
    if (cap_oor) resp_data = 8'hFF;
  end

  // Live RAM data in RESP, then held until the next fetch/read.
  assign mem_rdata = (state == ST_RESP && is_rd) ? resp_data : rdata_q;

  always_ff @(posedge clk) begin
    if (sys_rst)
      rdata_q <= 8'h00;
    else if (state == ST_RESP && is_rd)
      rdata_q <= resp_data;
  end

  mc51_sp_ram #(.AW(CODE_AW), .DW(8)) u_code (
    .clk   (clk),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_wdata),
    .re    (fire && cap_acc == ACC_FETCH),
    .raddr (cap_addr[CODE_AW-1:0]),
    .rdata (code_q)
  );

  mc51_sp_ram #(.AW(XRAM_AW), .DW(8)) u_xram (
    .clk   (clk),
    .we    (fire && cap_acc == ACC_WRITE && !cap_oor),
    .waddr (cap_addr[XRAM_AW-1:0]),
    .wdata (cap_wdata),
    .re    (fire && cap_acc == ACC_READ),
    .raddr (cap_addr[XRAM_AW-1:0]),
    .rdata (xram_q)
  );

endmodule

// File: tb/tb_mc51_ext_mem_resp.sv
// Bench for mc51_ext_mem_resp: two instances (63 and 0 wait cycles).
// Random and directed accesses checked against a memory-level model.
module tb_mc51_ext_mem_resp;

  localparam int KF = 0;
  localparam int KR = 1;
  localparam int KW = 2;
  localparam int KFR = 3;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic [15:0] addr       [2];
  logic        psen_n     [2];
  logic        rd_n       [2];
  logic        we_n       [2];
  logic [7:0]  wdata      [2];
  logic [7:0]  rdata      [2];
  logic        rdy        [2];
  logic        prog_we    [2];
  logic [11:0] prog_addr  [2];
  logic [7:0]  prog_wdata [2];
`ifdef MC51_MEM_ERR_EN
  logic        err        [2];
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc51_ext_mem_resp u_a (
    .clk          (clk),
    .sys_rst      (rst[0]),
    .mem_addr     (addr[0]),
    .mem_psen_n   (psen_n[0]),
    .mem_rd_n     (rd_n[0]),
    .mem_we_n     (we_n[0]),
    .mem_wdata    (wdata[0]),
    .mem_rdata    (rdata[0]),
    .mem_data_rdy (rdy[0]),
`ifdef MC51_MEM_ERR_EN
    .mem_err      (err[0]),
`endif
    .prog_we      (prog_we[0]),
    .prog_addr    (prog_addr[0]),
    .prog_wdata   (prog_wdata[0])
  );

  mc51_ext_mem_resp #(.WAIT_CYC(0)) u_b (
    .clk          (clk),
    .sys_rst      (rst[1]),
    .mem_addr     (addr[1]),
    .mem_psen_n   (psen_n[1]),
    .mem_rd_n     (rd_n[1]),
    .mem_we_n     (we_n[1]),
    .mem_wdata    (wdata[1]),
    .mem_rdata    (rdata[1]),
    .mem_data_rdy (rdy[1]),
`ifdef MC51_MEM_ERR_EN
    .mem_err      (err[1]),
`endif
    .prog_we      (prog_we[1]),
    .prog_addr    (prog_addr[1]),
    .prog_wdata   (prog_wdata[1])
  );

  // Reference model: memory contents plus remaining busy cycles.
  logic [7:0]  code_m [2][4096];
  bit          code_k [2][4096];
  logic [7:0]  xram_m [2][1024];
  bit          xram_k [2][1024];
  int          left   [2];
  bit          in_resp[2];
  logic [7:0]  exp_rd [2];
  bit          exp_kn [2];
  int          pk     [2];
  logic [15:0] pa     [2];
  logic [7:0]  pw     [2];
  bit          armed = 1'b0;

  function automatic int wc(input int u);
    return (u == 0) ? 63 : 0;
  endfunction

  function automatic bit oor(input int k, input logic [15:0] a);
`ifdef MC51_MEM_ERR_EN
    return (k == KF) ? (a >= 16'd4096) : (a >= 16'd1024);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (prog_we[u] === 1'b1) begin
        code_m[u][prog_addr[u]] = prog_wdata[u];
        code_k[u][prog_addr[u]] = 1'b1;
      end
      if (rst[u] === 1'b1) begin
        left[u] = 0; in_resp[u] = 0;
        exp_rd[u] = 8'h00; exp_kn[u] = 1;
      end else if (left[u] > 0) begin
        left[u]--;
        if (left[u] == 0) begin
          in_resp[u] = 1;
          if (pk[u] == KW) begin
            if (!oor(KW, pa[u])) begin
              xram_m[u][pa[u] % 1024] = pw[u];
              xram_k[u][pa[u] % 1024] = 1;
            end
          end else if (oor(pk[u], pa[u])) begin
            exp_rd[u] = 8'hFF; exp_kn[u] = 1;
          end else if (pk[u] == KF) begin
            exp_rd[u] = code_m[u][pa[u] % 4096];
            exp_kn[u] = code_k[u][pa[u] % 4096];
          end else begin
            exp_rd[u] = xram_m[u][pa[u] % 1024];
            exp_kn[u] = xram_k[u][pa[u] % 1024];
          end
        end
      end else if (in_resp[u]) begin
        in_resp[u] = 0;
      end else if (!(psen_n[u] && rd_n[u] && we_n[u])) begin
        pk[u]   = !psen_n[u] ? KF : (!rd_n[u] ? KR : KW);
        pa[u]   = addr[u];
        pw[u]   = wdata[u];
        left[u] = wc(u) + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("rdy%0d", u), 32'(rdy[u]), 32'(left[u] == 0));
        if (exp_kn[u])
          chk($sformatf("rdata%0d", u), 32'(rdata[u]), 32'(exp_rd[u]));
`ifdef MC51_MEM_ERR_EN
        chk($sformatf("err%0d", u), 32'(err[u]),
            32'(in_resp[u] && pk[u] != KW ? oor(pk[u], pa[u]) :
                in_resp[u] && oor(KW, pa[u])));
`endif
      end
    end
  end

  task automatic access(input int u, input int k, input logic [15:0] a,
                        input logic [7:0] d, input bit noise,
                        output int lows, output logic [7:0] rd);
    @(negedge clk);
    addr[u] = a; wdata[u] = d;
    psen_n[u] = !(k == KF || k == KFR);
    rd_n[u]   = !(k == KR || k == KFR);
    we_n[u]   = !(k == KW);
    @(negedge clk);
    lows = 0;
    while (rdy[u] !== 1'b1 && lows < 1000) begin
      lows++;
      if (noise) begin
        addr[u]       = 16'($urandom);
        psen_n[u]     = 1'($urandom);
        rd_n[u]       = 1'($urandom);
        we_n[u]       = 1'($urandom);
        prog_we[u]    = ($urandom_range(0, 3) == 0);
        prog_addr[u]  = 12'($urandom_range(0, 15));
        prog_wdata[u] = 8'($urandom);
      end
      @(negedge clk);
    end
    psen_n[u] = 1; rd_n[u] = 1; we_n[u] = 1; prog_we[u] = 0;
    rd = rdata[u];
    chk("timeout", 32'(lows < 1000), 32'd1);
  endtask

  task automatic prog(input int u, input int a, input logic [7:0] d);
    @(negedge clk);
    prog_we[u] = 1; prog_addr[u] = 12'(a); prog_wdata[u] = d;
    @(negedge clk);
    prog_we[u] = 0;
  endtask

  int         lows;
  logic [7:0] rd;

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1; addr[u] = 0; psen_n[u] = 1; rd_n[u] = 1; we_n[u] = 1;
      wdata[u] = 0; prog_we[u] = 0; prog_addr[u] = 0; prog_wdata[u] = 0;
      left[u] = 0; in_resp[u] = 0; exp_rd[u] = 0; exp_kn[u] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_rdy_a", 32'(rdy[0]), 32'd1);
    chk("rst_rdata_a", 32'(rdata[0]), 32'h00);
    chk("rst_rdy_b", 32'(rdy[1]), 32'd1);
    chk("rst_rdata_b", 32'(rdata[1]), 32'h00);
    rst[0] = 0; rst[1] = 0;
    armed = 1;

    for (int i = 0; i < 64; i++)
      prog(0, i, (i == 2) ? 8'h74 : (i == 3) ? 8'h03 : 8'($urandom));
    for (int i = 0; i < 4; i++)
      prog(1, i, 8'h40 + 8'(i * 7));

    access(0, KF, 16'h0002, 8'h00, 0, lows, rd);
    chk("fetch_lows", 32'(lows), 32'd64);
    chk("fetch_data", 32'(rd), 32'h74);

    access(0, KW, 16'h0010, 8'h5A, 0, lows, rd);
    chk("write_hold", 32'(rd), 32'h74);
    access(0, KR, 16'h0010, 8'h00, 0, lows, rd);
    chk("read_back", 32'(rd), 32'h5A);

    access(0, KW, 16'h0003, 8'h99, 0, lows, rd);
    access(0, KFR, 16'h0003, 8'h00, 0, lows, rd);
    chk("prio_data", 32'(rd), 32'h03);
    chk("prio_lows", 32'(lows), 32'd64);
    access(0, KR, 16'h0003, 8'h00, 0, lows, rd);
    chk("prio_xram", 32'(rd), 32'h99);

    access(0, KW, 16'h0020, 8'h66, 0, lows, rd);
    @(negedge clk);
    addr[0] = 16'h0020; wdata[0] = 8'h11; we_n[0] = 0;
    @(negedge clk);
    we_n[0] = 1;
    repeat (9) @(negedge clk);
    rst[0] = 1;
    @(negedge clk);
    chk("abort_rdy", 32'(rdy[0]), 32'd1);
    chk("abort_rdata", 32'(rdata[0]), 32'h00);
    rst[0] = 0;
    access(0, KR, 16'h0020, 8'h00, 0, lows, rd);
    chk("abort_old", 32'(rd), 32'h66);

    access(0, KW, 16'h0000, 8'h3C, 0, lows, rd);
    access(0, KR, 16'h8000, 8'h00, 0, lows, rd);
`ifdef MC51_MEM_ERR_EN
    chk("oor_data", 32'(rd), 32'hFF);
    chk("oor_err_hi", 32'(err[0]), 32'd1);
    @(negedge clk);
    chk("oor_err_lo", 32'(err[0]), 32'd0);
`else
    chk("alias_data", 32'(rd), 32'h3C);
`endif

    // Back-to-back fetches with psen held low on the zero-wait instance.
    @(negedge clk);
    psen_n[1] = 0; addr[1] = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      int lo;
      int hi;
      lo = 0; hi = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (!rdy[1]) lo++;
        else if (lo > 0) break;
        else hi++;
      end
      chk($sformatf("b2b_lows%0d", i), 32'(lo), 32'd1);
      if (i > 0) chk($sformatf("b2b_gap%0d", i), 32'(hi), 32'd1);
      chk($sformatf("b2b_data%0d", i), 32'(rdata[1]), 32'h40 + 32'(i * 7));
      addr[1] = 16'(i + 1);
    end
    psen_n[1] = 1;

    for (int i = 0; i < 60; i++)
      access(0, $urandom_range(0, 2), 16'($urandom) & 16'hF01F,
             8'($urandom), 1, lows, rd);
    for (int i = 0; i < 300; i++)
      access(1, $urandom_range(0, 2), 16'($urandom) & 16'hF003,
             8'($urandom), 1, lows, rd);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
